// File: rtl/alu_req_scheduler_pkg.sv
// Shared types and defaults for the two-requester ALU scheduler.
package alu_sched_pkg;

    // Requester index width (two requesters).
    localparam int REQ_ID_W  = 1;

    // Default datapath geometry.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_OP_W  = 2;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/alu_req_scheduler_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// the previous accepted grant wins. The history only moves when the
// consumer strobes update, so a grant that is offered but not taken
// does not disturb fairness.
module rr_arb2
    import alu_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid0,
    input  logic                valid1,
    input  logic                update,
    output logic [1:0]          grant,
    output logic [REQ_ID_W-1:0] grant_idx
);

    logic [REQ_ID_W-1:0] last_grant_r;

    // Pick the winner from the two valids and the previous grant.
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        if (valid0 && valid1) begin
            if (last_grant_r == 1'b1) begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end else begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
        end else if (valid0) begin
            grant     = 2'b01;
            grant_idx = 1'b0;
        end else if (valid1) begin
            grant     = 2'b10;
            grant_idx = 1'b1;
        end else begin
            grant     = 2'b00;
            grant_idx = 1'b0;
        end
    end

    // Remember the last accepted grant; reset favours requester 0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (update) begin
            last_grant_r <= grant_idx;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between two requesters: round-robin accept, drive the
// captured operands for ALU_LAT cycles, sample the result and return it
// on a valid/ready channel tagged with the requester index.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OP_W    = DEF_OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic [OP_W-1:0]     req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic [OP_W-1:0]     req1_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [REQ_ID_W-1:0] rsp_id,
    output logic [WIDTH-1:0]    rsp_result,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [OP_W-1:0]     alu_pb,
    input  logic [WIDTH-1:0]    alu_led,
    output logic                busy,
    output logic [7:0]          ops_done
);

    localparam int             CNT_W    = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sched_state_e        state_r;
    sched_state_e        state_nxt;
    logic [CNT_W-1:0]    cnt_r;
    logic [1:0]          grant;
    logic [REQ_ID_W-1:0] grant_idx;
    logic                accept;
    logic                exec_last;
    logic                rsp_fire;

    // Handshake and phase strobes derived from the current state.
    always_comb begin
        accept    = (state_r == ST_IDLE) && (req0_valid || req1_valid);
        exec_last = (state_r == ST_EXEC) && (cnt_r == CNT_LAST);
        rsp_fire  = (state_r == ST_RESP) && rsp_ready;
    end

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic; RESP always falls back to IDLE so a new
    // acceptance can never coincide with the response handshake.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_EXEC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (exec_last) begin
                    state_nxt = ST_RESP;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: ready only in IDLE for the granted side, never payload-dependent.
    always_comb begin
        req0_ready = (state_r == ST_IDLE) && grant[0];
        req1_ready = (state_r == ST_IDLE) && grant[1];
        rsp_valid  = (state_r == ST_RESP);
        busy       = (state_r != ST_IDLE);
    end

    // EXEC cycle counter: holds 1 in the first EXEC cycle, ALU_LAT in the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (accept) begin
            cnt_r <= CNT_ONE;
        end else if ((state_r == ST_EXEC) && !exec_last) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Capture the granted payload into the ALU drive registers and tag the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_pb <= '0;
            rsp_id <= '0;
        end else if (accept) begin
            if (grant_idx == 1'b1) begin
                alu_a  <= req1_a;
                alu_b  <= req1_b;
                alu_pb <= req1_op;
            end else begin
                alu_a  <= req0_a;
                alu_b  <= req0_b;
                alu_pb <= req0_op;
            end
            rsp_id <= grant_idx;
        end else begin
            alu_a  <= alu_a;
            alu_b  <= alu_b;
            alu_pb <= alu_pb;
            rsp_id <= rsp_id;
        end
    end

    // Sample the ALU result on the last settle cycle; held through any stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= '0;
        end else if (exec_last) begin
            rsp_result <= alu_led;
        end else begin
            rsp_result <= rsp_result;
        end
    end

    // Count completed response handshakes, wrapping at 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done <= 8'd0;
        end else if (rsp_fire) begin
            ops_done <= ops_done + 8'd1;
        end else begin
            ops_done <= ops_done;
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: one instance with ALU_LAT=1 and one with
// ALU_LAT=3, selected by sel. A cycle-level reference model tracks the
// outstanding operation and predicts ready, response and ALU drive values.
module tb_alu_req_scheduler;

    logic       clk = 1'b0;
    logic       rst, sel, req0_valid, req1_valid, rsp_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       ovr_en;
    logic [7:0] ovr_val;

    logic       d1_r0, d1_r1, d1_rv, d1_id, d1_busy;
    logic [7:0] d1_res, d1_a, d1_b, d1_ops, led1;
    logic [1:0] d1_pb;
    logic       d3_r0, d3_r1, d3_rv, d3_id, d3_busy;
    logic [7:0] d3_res, d3_a, d3_b, d3_ops, led3;
    logic [1:0] d3_pb;

    logic       o_r0, o_r1, o_rv, o_id, o_busy;
    logic [7:0] o_res, o_a, o_b, o_ops;
    logic [1:0] o_pb;

    always #5 clk = ~clk;

    // Stand-in ALU behaviour.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign led1 = ovr_en ? ovr_val : alu_f(d1_a, d1_b, d1_pb);
    assign led3 = ovr_en ? ovr_val : alu_f(d3_a, d3_b, d3_pb);

    alu_req_scheduler #(.WIDTH(8), .OP_W(2), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid & ~sel), .req0_ready(d1_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid & ~sel), .req1_ready(d1_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(d1_rv), .rsp_ready(rsp_ready & ~sel), .rsp_id(d1_id), .rsp_result(d1_res),
        .alu_a(d1_a), .alu_b(d1_b), .alu_pb(d1_pb), .alu_led(led1), .busy(d1_busy), .ops_done(d1_ops)
    );

    alu_req_scheduler #(.WIDTH(8), .OP_W(2), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid & sel), .req0_ready(d3_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid & sel), .req1_ready(d3_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(d3_rv), .rsp_ready(rsp_ready & sel), .rsp_id(d3_id), .rsp_result(d3_res),
        .alu_a(d3_a), .alu_b(d3_b), .alu_pb(d3_pb), .alu_led(led3), .busy(d3_busy), .ops_done(d3_ops)
    );

    assign o_r0   = sel ? d3_r0   : d1_r0;
    assign o_r1   = sel ? d3_r1   : d1_r1;
    assign o_rv   = sel ? d3_rv   : d1_rv;
    assign o_id   = sel ? d3_id   : d1_id;
    assign o_busy = sel ? d3_busy : d1_busy;
    assign o_res  = sel ? d3_res  : d1_res;
    assign o_a    = sel ? d3_a    : d1_a;
    assign o_b    = sel ? d3_b    : d1_b;
    assign o_pb   = sel ? d3_pb   : d1_pb;
    assign o_ops  = sel ? d3_ops  : d1_ops;

    // Reference model state
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         acc_cyc = 0;
    int         hs    = 0;
    bit         pend  = 1'b0;
    logic       lg    = 1'b1;
    logic [7:0] ops_m = 8'd0;
    logic [7:0] drv_a = 8'd0, drv_b = 8'd0, exp_res = 8'd0;
    logic [1:0] drv_op = 2'd0;
    logic       exp_id = 1'b0;
    bit         hold0 = 1'b0, hold1 = 1'b0;
    int         grant_log[$];
    logic [7:0] p_a0, p_b0, p_a1, p_b1;
    logic [1:0] p_op0, p_op1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, predict, compare, advance the model.
    task automatic cycle(input logic v0, input logic v1, input logic rr);
        int   lat;
        logic er0, er1, erv, win;
        lat        = sel ? 3 : 1;
        req0_valid = v0;   req1_valid = v1;   rsp_ready = rr;
        req0_a = p_a0; req0_b = p_b0; req0_op = p_op0;
        req1_a = p_a1; req1_b = p_b1; req1_op = p_op1;
        #1;
        er0 = 1'b0;
        er1 = 1'b0;
        if (!pend) begin
            if (v0 && v1) begin
                er0 = lg;
                er1 = ~lg;
            end else begin
                er0 = v0;
                er1 = v1;
            end
        end
        erv = pend && (cyc >= acc_cyc + lat + 1);
        chk("req0_ready", o_r0, er0);
        chk("req1_ready", o_r1, er1);
        chk("busy", o_busy, pend);
        chk("rsp_valid", o_rv, erv);
        if (erv) begin
            chk("rsp_id", o_id, exp_id);
            chk("rsp_result", o_res, exp_res);
        end
        chk("alu_a", o_a, drv_a);
        chk("alu_b", o_b, drv_b);
        chk("alu_pb", o_pb, drv_op);
        chk("ops_done", o_ops, ops_m);
        if (pend && (cyc == acc_cyc + lat))
            exp_res = ovr_en ? ovr_val : alu_f(drv_a, drv_b, drv_op);
        if (!pend && (v0 || v1)) begin
            win     = er1;
            pend    = 1'b1;
            acc_cyc = cyc;
            lg      = win;
            exp_id  = win;
            if (win) begin
                drv_a = p_a1; drv_b = p_b1; drv_op = p_op1; hold1 = 1'b0;
            end else begin
                drv_a = p_a0; drv_b = p_b0; drv_op = p_op0; hold0 = 1'b0;
            end
            grant_log.push_back(int'(o_r1));
        end else if (erv && rr) begin
            pend  = 1'b0;
            ops_m = ops_m + 8'd1;
            hs++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0; ovr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend = 1'b0; lg = 1'b1; ops_m = 8'd0;
        drv_a = 8'd0; drv_b = 8'd0; drv_op = 2'd0;
        hold0 = 1'b0; hold1 = 1'b0;
        cyc++;
        #1;
        chk("rst_req0_ready", o_r0, 1'b0);
        chk("rst_req1_ready", o_r1, 1'b0);
        chk("rst_rsp_valid", o_rv, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ops_done", o_ops, 8'd0);
        chk("rst_alu_a", o_a, 8'd0);
        chk("rst_alu_b", o_b, 8'd0);
        chk("rst_alu_pb", o_pb, 2'd0);
        chk("rst_rsp_id", o_id, 1'b0);
        chk("rst_rsp_result", o_res, 8'd0);
    endtask

    task automatic rand_cycle();
        if (!hold0) hold0 = ($urandom_range(0, 2) == 0);
        if (!hold1) hold1 = ($urandom_range(0, 2) == 0);
        p_a0 = 8'($urandom); p_b0 = 8'($urandom); p_op0 = 2'($urandom);
        p_a1 = 8'($urandom); p_b1 = 8'($urandom); p_op1 = 2'($urandom);
        cycle(hold0, hold1, ($urandom_range(0, 3) != 0));
    endtask

    task automatic drain();
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int k = 0; k < 40 && pend; k++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; ovr_en = 1'b0; ovr_val = 8'd0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        p_a0 = 8'd0; p_b0 = 8'd0; p_op0 = 2'd0; p_a1 = 8'd0; p_b1 = 8'd0; p_op1 = 2'd0;
        req0_a = 8'd0; req0_b = 8'd0; req0_op = 2'd0; req1_a = 8'd0; req1_b = 8'd0; req1_op = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single request, ALU_LAT=1
        p_a0 = 8'h12; p_b0 = 8'h34; p_op0 = 2'b00;
        cycle(1'b1, 1'b0, 1'b1);
        chk("single_alu_a", o_a, 8'h12);
        chk("single_alu_b", o_b, 8'h34);
        chk("single_alu_pb", o_pb, 2'b00);
        cycle(1'b0, 1'b0, 1'b1);
        chk("single_rsp_valid", o_rv, 1'b1);
        chk("single_rsp_id", o_id, 1'b0);
        chk("single_rsp_result", o_res, 8'h46);
        cycle(1'b0, 1'b0, 1'b1);
        chk("single_ops_done", o_ops, 8'd1);

        // Continuous ties after reset alternate starting with req0
        do_reset();
        grant_log.delete();
        for (int k = 0; k < 100 && grant_log.size() < 8; k++) begin
            p_a0 = 8'($urandom); p_b0 = 8'($urandom); p_op0 = 2'($urandom);
            p_a1 = 8'($urandom); p_b1 = 8'($urandom); p_op1 = 2'($urandom);
            cycle(1'b1, 1'b1, 1'b1);
        end
        chk("tie_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) chk("tie_alternate", grant_log[i], i % 2);
        drain();

        // Backpressure with req1 pending
        grant_log.delete();
        p_a0 = 8'hA5; p_b0 = 8'h3C; p_op0 = 2'b01;
        p_a1 = 8'h0F; p_b1 = 8'hF0; p_op1 = 2'b11;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        chk("bp_hold_valid", o_rv, 1'b1);
        chk("bp_hold_result", o_res, 8'h69);
        chk("bp_req1_wait", o_r1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("bp_accept_count", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("bp_accept_req1", grant_log[1], 1);
        drain();

        // ALU_LAT=3: result sampled on the last settle cycle only
        sel = 1'b1;
        do_reset();
        p_a0 = 8'h21; p_b0 = 8'h43; p_op0 = 2'b10;
        cycle(1'b1, 1'b0, 1'b1);
        ovr_en = 1'b1; ovr_val = 8'hFF;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("lat3_not_yet", o_rv, 1'b0);
        ovr_val = 8'h5A;
        cycle(1'b0, 1'b0, 1'b1);
        ovr_en = 1'b0;
        chk("lat3_valid", o_rv, 1'b1);
        chk("lat3_result", o_res, 8'h5A);
        chk("lat3_alu_a", o_a, 8'h21);
        cycle(1'b0, 1'b0, 1'b1);

        // Reset in the middle of EXEC drops the op and restores tie priority
        p_a0 = 8'h77; p_b0 = 8'h11; p_op0 = 2'b00;
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        do_reset();
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        grant_log.delete();
        cycle(1'b1, 1'b1, 1'b1);
        chk("rst_tie_size", grant_log.size(), 1);
        if (grant_log.size() == 1) chk("rst_tie_req0", grant_log[0], 0);
        drain();

        // Random traffic on the ALU_LAT=3 instance
        repeat (300) rand_cycle();
        drain();

        // Random traffic on ALU_LAT=1 until 256 handshakes; counter wraps to 0
        sel = 1'b0;
        do_reset();
        hs = 0;
        for (int k = 0; k < 20000 && hs < 256; k++) rand_cycle();
        chk("wrap_count", hs, 256);
        chk("ops_wrap", o_ops, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Shares the 8-bit ALU datapath (operands `a`, `b`, 2-bit op select `PB`, 8-bit result `led`) between two requesters. Round-robin arbitration, operand/op capture, ALU drive for a fixed settle time, and result return on a valid/ready channel tagged with the requester ID. Sits between the bit-serial CPU control logic and the ALU instance. It is the only driver of the ALU inputs.

## Interface
- `WIDTH`, 8: operand and result width.
- `OP_W`, 2: op-select width, passed unmodified to ALU `PB`.
- `ALU_LAT`, 1: cycles operands are held on the ALU before the result is sampled; legal range 1..15.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a command.
- `req0_ready` out 1: requester 0 command accepted this cycle when high with valid.
- `req0_a`, `req0_b` in WIDTH: requester 0 operands.
- `req0_op` in OP_W: requester 0 op select.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same for requester 1.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_id` out 1: requester that issued the result.
- `rsp_result` out WIDTH: sampled ALU result.
- `alu_a`, `alu_b` out WIDTH: registered drive to ALU `a`, `b`.
- `alu_pb` out OP_W: registered drive to ALU `PB`.
- `alu_led` in WIDTH: ALU result (`led`).
- `busy` out 1: high in any state other than IDLE.
- `ops_done` out 8: count of completed response handshakes, wraps 255→0.

## Operation
- FSM states:
  - IDLE: if any `reqN_valid` is high, accept exactly one and go to EXEC.
  - EXEC: count `ALU_LAT` cycles. On the last one, register `alu_led` into `rsp_result` and go to RESP.
  - RESP: hold `rsp_valid` high. On `rsp_valid && rsp_ready`, return to IDLE.
- Arbitration, IDLE only:
  - Only one requester valid: grant it.
  - Both valid: grant the requester other than `last_grant`.
  - `last_grant` updates only on acceptance.
  - Reset value of `last_grant` is 1, so req0 wins the first tie.
- `reqN_ready` is high only in IDLE and only for the granted requester. It may depend combinationally on both valids. It never depends on the request payload.
- On acceptance, register these in the same edge:
  - `alu_a`/`alu_b`/`alu_pb` from the granted payload.
  - `rsp_id` ← granted index.
- ALU drive values hold until the next acceptance, including through RESP and IDLE.
- Opcode is not decoded. Any `OP_W` value is forwarded.
- Dropping `reqN_valid` before ready has no effect. Payload is not required to stay stable while not accepted.
- A request that is valid during EXEC/RESP waits with ready low and is never lost.
- `ops_done` increments on each response handshake, modulo 256.

## Timing
- Reset values:
  - FSM=IDLE.
  - All ready and valid outputs 0.
  - `alu_a`/`alu_b`/`alu_pb` = 0, `rsp_result` = 0, `rsp_id` = 0.
  - `busy` = 0, `ops_done` = 0, `last_grant` = 1.
- Accept at edge T. EXEC spans cycles T+1..T+ALU_LAT. `rsp_result` is sampled at edge T+ALU_LAT. `rsp_valid` is high from cycle T+ALU_LAT+1.
- Minimum spacing between acceptances is ALU_LAT+2 cycles. After the response handshake edge, the FSM is in IDLE for one cycle before it can accept.
- The response handshake and a new acceptance never happen in the same cycle.
- `rsp_valid`, `rsp_id` and `rsp_result` are stable while `rsp_ready` is low. Stall length is unbounded.
- Reset asserted mid-EXEC or mid-RESP: the operation is dropped with no response, and all state returns to reset values at the next edge.

## Structure
- Package `alu_sched_pkg`:
  - FSM state enum (IDLE, EXEC, RESP).
  - `REQ_ID_W`=1.
  - Localparam defaults for `WIDTH`/`OP_W`.
- Sub-module `rr_arb2`: 2-input round-robin arbiter with `last_grant` register. Inputs are the two valids plus an update strobe. Outputs are the one-hot grant and its index.
- The EXEC counter is `$clog2(ALU_LAT+1)` bits.

## Test plan
- Single request, `ALU_LAT`=1: req0 a=0x12 b=0x34 op=2'b00 accepted at T → alu_a=0x12, alu_b=0x34, alu_pb=00 at T+1; `rsp_valid` at T+2 with `rsp_id`=0 and `rsp_result` equal to model `led`; `ops_done`=1.
- Tie after reset: both valid at once → req0 granted first, req1 on the next IDLE. Continuous ties alternate 0,1,0,1 over 8 ops.
- Backpressure: `rsp_ready` low for 10 cycles → `rsp_valid`/`rsp_result`/`rsp_id` held constant; req1 pending with `req1_ready`=0 throughout; accepted on the first IDLE cycle after the handshake.
- `ALU_LAT`=3: `alu_led` driven 0xFF in EXEC cycles 1-2 and 0x5A in cycle 3 → `rsp_result`=0x5A; `rsp_valid` rises exactly 4 cycles after acceptance.
- Reset mid-EXEC: `rst` high for 1 cycle → no `rsp_valid`, all outputs at reset values; next tie grants req0.
- Counter wrap: 256 handshakes → `ops_done` returns to 0x00.
